spike_packet_scheduler: RTL
===========================

# spike_packet_scheduler

Sequencer for a core's outgoing spike traffic. It latches per-neuron spike pulses into a pending vector and arbitrates among pending neurons. For each granted neuron it walks that neuron's CSR range of downstream connections and emits one 24-bit packet {source address, destination address} per connection over a valid/ready handshake. It sits between the neuron accumulators/adders and the router injection port, and holds the per-core connection tables behind a serial configuration write port.

## Interface
- NUM_NEURONS, 10, neurons served; pointer table has NUM_NEURONS+1 entries
- ADDR_W, 12, neuron/destination address width; packet width is 2*ADDR_W
- PTR_W, 5, connection pointer width
- MAX_CONN, 30, downstream table depth

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- clear  in  1  timestep start: flush pending work
- spike_in  in  NUM_NEURONS  per-neuron spike pulses, sampled every edge
- cfg_we  in  1  table write strobe
- cfg_sel  in  2  table select: 0 neuron address, 1 connection pointer, 2 downstream; 3 ignored
- cfg_addr  in  PTR_W  table index
- cfg_data  in  ADDR_W  write data; pointer writes use low PTR_W bits
- packet  out  2*ADDR_W  {neuron_addr[g], downstream[j]}
- packet_valid  out  1  packet is valid
- packet_ready  in  1  downstream accepts the packet
- busy  out  1  pending != 0 or state == SEND

## Operation
- Pending capture: every edge, `pending <= (pending & ~grant_mask) | spike_in`.
  - A spike on a neuron that is already pending merges into the existing request.
  - A spike on the neuron currently in SEND sets pending again; that neuron is served again later.
- FSM states are IDLE and SEND.
  - IDLE with pending != 0: select g, clear pending[g], load j = ptr[g] and end = ptr[g+1].
    - If j < end and end <= MAX_CONN, go to SEND.
    - Otherwise the range is empty or invalid: the neuron is consumed, no packet is emitted, and the FSM stays in IDLE. Another grant is possible on the next edge.
  - SEND: packet_valid = 1 and packet = {addr[g], down[j]}.
    - On valid && ready: j++.
    - If j+1 == end, return to IDLE. IDLE may re-grant on the following edge.
- Arbitration is lowest pending index, or round-robin (see Configuration).
- Table writes are applied on the edge when cfg_we = 1 and busy = 0. Writes while busy = 1, or out-of-range indices, are dropped.
- clear has priority over the FSM:
  - pending is loaded with spike_in of that same cycle; those spikes belong to the new timestep.
  - The FSM goes to IDLE and packet_valid drops on the next edge.
  - Remaining connections of the in-flight neuron are discarded.
- Reset values: packet = 0, packet_valid = 0, busy = 0, pending = 0, all tables = 0, state = IDLE, round-robin pointer = NUM_NEURONS-1.

## Timing
- spike_in sampled at edge t → grant at edge t+1 → packet_valid high from t+1. Latency is 2 edges.
- Throughput is 1 packet per cycle with packet_ready held high. The IDLE bubble between neurons is 1 cycle.
- packet and packet_valid are registered. While valid && !ready they hold stable; packet_valid never drops except on clear or RESET.
- packet_ready is ignored while packet_valid = 0.
- RESET asserted mid-SEND clears everything immediately, asynchronously. Deassertion is synchronized by the integrator.
- All pointer comparisons are unsigned PTR_W. No wrap-around is permitted; end > MAX_CONN is treated as an empty range.

## Configuration
- SPIKE_SCHED_ROUND_ROBIN_EN defined:
  - Grant goes to the first pending index after the last grant, wrapping modulo NUM_NEURONS.
  - The pointer updates on each grant, including grants with an empty range.
- Not defined: fixed priority, lowest pending index wins; no round-robin pointer register.

## Test plan
Common preload: addr[i] = 0x100+i; ptr = {0,3,5,5,5,5,5,5,5,5,5}; down[j] = 0x200+j.

1. RESET pulse mid-operation → packet = 0x000000, packet_valid = 0, busy = 0 immediately; tables read back zero behaviour (spike → no packets).
2. Preload, spike_in = 10'b1 for 1 cycle, ready = 1 → 0x100200, 0x100201, 0x100202 on three consecutive cycles starting 2 edges after the spike; busy low 1 cycle after the last accept.
3. As 2 with ready low for 4 cycles while 0x100201 is presented → packet held at 0x100201 and valid stays high; sequence completes with no loss or duplicate.
4. spike_in = 10'b0000000111 → neuron 0's three packets, then 0x101203, 0x101204; neuron 2 (ptr[2] = ptr[3] = 5) emits nothing; total 5 packets.
5. With SPIKE_SCHED_ROUND_ROBIN_EN: serve neuron 0, then spike neurons 0 and 1 together → neuron 1's packets precede neuron 0's. Without the macro → neuron 0 first.
6. clear asserted on the cycle 0x100201 is valid, with spike_in = bit 1 → valid low on the next edge and 0x100202 never appears; then 0x101203, 0x101204 are emitted. A cfg_we during busy leaves the tables unchanged.

Source files
------------

// File: rtl/spike_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spike_packet_scheduler
// Brief    : Latches per-neuron spikes, arbitrates pending neurons and emits
//            one {source, destination} packet per downstream connection.
//            Optional macro SPIKE_SCHED_ROUND_ROBIN_EN selects round-robin
//            arbitration; the default is lowest-pending-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module spike_packet_scheduler #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int PTR_W       = 5,
    parameter int MAX_CONN    = 30
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   clear,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [PTR_W-1:0]       cfg_addr,
    input  logic [ADDR_W-1:0]      cfg_data,
    output logic [2*ADDR_W-1:0]    packet,
    output logic                   packet_valid,
    input  logic                   packet_ready,
    output logic                   busy
);
    localparam int             c_IDX_W    = $clog2(NUM_NEURONS + 1);
    localparam logic [PTR_W:0] c_MAX_CONN = (PTR_W + 1)'(MAX_CONN);
    localparam logic [PTR_W:0] c_N_ADDR   = (PTR_W + 1)'(NUM_NEURONS);
    localparam logic [PTR_W:0] c_N_PTR    = (PTR_W + 1)'(NUM_NEURONS + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_addr_tbl [NUM_NEURONS];
    logic [PTR_W-1:0]       r_ptr_tbl  [NUM_NEURONS+1];
    logic [ADDR_W-1:0]      r_down_tbl [MAX_CONN];
    logic [NUM_NEURONS-1:0] r_pending;
    logic [c_IDX_W-1:0]     r_g;
    logic [PTR_W-1:0]       r_j;
    logic [PTR_W-1:0]       r_end;

    logic [NUM_NEURONS-1:0] w_search;
    logic [c_IDX_W-1:0]     w_first;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic                   w_grant;
    logic [NUM_NEURONS-1:0] w_grant_mask;
    logic [PTR_W-1:0]       w_start;
    logic [PTR_W-1:0]       w_stop;
    logic                   w_range_ok;
    logic [PTR_W-1:0]       w_j_next;

    // Lowest set bit of the (possibly rotated) request vector.
    always_comb begin
        w_first = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (w_search[i]) w_first = c_IDX_W'(i);
        end
    end

`ifdef SPIKE_SCHED_ROUND_ROBIN_EN
    localparam logic [c_IDX_W:0] c_NN = (c_IDX_W + 1)'(NUM_NEURONS);

    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W:0]   w_rr_sum;

    // Rotate so bit 0 is the neuron just after the last grant.
    assign w_search    = NUM_NEURONS'({r_pending, r_pending} >> (r_rr_ptr + 1'b1));
    assign w_rr_sum    = {1'b0, r_rr_ptr} + {1'b0, w_first} + 1'b1;
    assign w_grant_idx = (w_rr_sum >= c_NN) ? c_IDX_W'(w_rr_sum - c_NN)
                                            : w_rr_sum[c_IDX_W-1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rr_ptr <= c_IDX_W'(NUM_NEURONS - 1);
        end else if (w_grant) begin
            r_rr_ptr <= w_grant_idx;
        end
    end
`else
    assign w_search    = r_pending;
    assign w_grant_idx = w_first;
`endif

    assign w_grant      = (r_state == ST_IDLE) && (r_pending != '0) && !clear;
    assign w_grant_mask = w_grant ? (NUM_NEURONS'(1) << w_grant_idx) : '0;
    assign w_start      = r_ptr_tbl[w_grant_idx];
    assign w_stop       = r_ptr_tbl[w_grant_idx + 1'b1];
    assign w_range_ok   = (w_start < w_stop) && ({1'b0, w_stop} <= c_MAX_CONN);
    assign w_j_next     = r_j + 1'b1;
    assign busy         = (r_pending != '0) || (r_state == ST_SEND);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_g          <= '0;
            r_j          <= '0;
            r_end        <= '0;
            packet       <= '0;
            packet_valid <= 1'b0;
        end else if (clear) begin
            // New timestep: spikes of this cycle survive, in-flight work is dropped.
            r_pending    <= spike_in;
            r_state      <= ST_IDLE;
            packet_valid <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_grant_mask) | spike_in;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant && w_range_ok) begin
                        r_state      <= ST_SEND;
                        r_g          <= w_grant_idx;
                        r_j          <= w_start;
                        r_end        <= w_stop;
                        packet       <= {r_addr_tbl[w_grant_idx], r_down_tbl[w_start]};
                        packet_valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (packet_ready) begin
                        if (w_j_next == r_end) begin
                            r_state      <= ST_IDLE;
                            packet_valid <= 1'b0;
                        end else begin
                            r_j    <= w_j_next;
                            packet <= {r_addr_tbl[r_g], r_down_tbl[w_j_next]};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tables are frozen while any work is pending or in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_NEURONS; i++)     r_addr_tbl[i] <= '0;
            for (int i = 0; i < NUM_NEURONS + 1; i++) r_ptr_tbl[i]  <= '0;
            for (int i = 0; i < MAX_CONN; i++)        r_down_tbl[i] <= '0;
        end else if (cfg_we && !busy) begin
            case (cfg_sel)
                2'd0: if ({1'b0, cfg_addr} < c_N_ADDR)
                          r_addr_tbl[cfg_addr[c_IDX_W-1:0]] <= cfg_data;
                2'd1: if ({1'b0, cfg_addr} < c_N_PTR)
                          r_ptr_tbl[cfg_addr[c_IDX_W-1:0]] <= cfg_data[PTR_W-1:0];
                2'd2: if ({1'b0, cfg_addr} < c_MAX_CONN)
                          r_down_tbl[cfg_addr] <= cfg_data;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
